// File: rtl/imem_loader_if.sv
// Stream-in / imem-write / status bundle for the instruction memory loader.
// The loader uses the slave side; the stream source uses the master side.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              restart;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              err;
   logic [15:0]       word_cnt;

   modport master (
      output in_valid, in_data, restart,
      input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err, word_cnt
   );

   modport slave (
      input  in_valid, in_data, restart,
      output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err, word_cnt
   );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a 16-bit word-count header and little-endian
// words, writes them to instruction memory, holding the core in reset until done.
module imem_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave lif
);

   localparam logic [2:0] S_LEN0  = 3'd0;
   localparam logic [2:0] S_LEN1  = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   logic [2:0]        state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       asm_q, asm_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [15:0]       n_full;
   logic              in_ready;
   logic              accept;

   assign in_ready = ((state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_LOAD))
                     && !lif.restart;
   assign accept   = lif.in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_cnt_d = word_cnt_q;
      n_full     = {lif.in_data, n_q[7:0]};

      if (lif.restart) begin
         state_d    = S_LEN0;
         byte_idx_d = '0;
         word_cnt_d = '0;
      end else begin
         case (state_q)
            S_LEN0: begin
               if (accept) begin
                  n_d[7:0] = lif.in_data;
                  state_d  = S_LEN1;
               end
            end
            S_LEN1: begin
               if (accept) begin
                  n_d        = n_full;
                  byte_idx_d = '0;
                  if (n_full == '0)
                     state_d = S_RUN;
                  else if ({1'b0, n_full} > DEPTH)
                     state_d = S_ERROR;
                  else
                     state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  if (byte_idx_q == 2'd3) begin
                     // Last byte goes straight into the write data; count advances with the strobe.
                     we_d       = 1'b1;
                     wdata_d    = {lif.in_data, asm_q};
                     addr_d     = word_cnt_q[ADDR_W-1:0];
                     word_cnt_d = word_cnt_q + 16'd1;
                     byte_idx_d = '0;
                     state_d    = (word_cnt_q == n_q - 16'd1) ? S_DRAIN : S_LOAD;
                  end else begin
                     case (byte_idx_q)
                        2'd0:    asm_d[7:0]   = lif.in_data;
                        2'd1:    asm_d[15:8]  = lif.in_data;
                        default: asm_d[23:16] = lif.in_data;
                     endcase
                     byte_idx_d = byte_idx_q + 2'd1;
                  end
               end
            end
            S_DRAIN: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_LEN0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_LEN0;
         n_q        <= '0;
         byte_idx_q <= '0;
         asm_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign lif.in_ready   = in_ready;
   assign lif.imem_we    = we_q;
   assign lif.imem_addr  = addr_q;
   assign lif.imem_wdata = wdata_q;
   assign lif.core_rst   = (state_q != S_RUN);
   assign lif.done       = (state_q == S_RUN);
   assign lif.err        = (state_q == S_ERROR);
   assign lif.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, random loads against a
// transaction-level model of the expected writes, and hand-written abort/timing cases.
module tb_imem_loader;
   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;

   imem_loader_if #(.ADDR_W(AW)) lif ();
   imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .lif(lif));

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
   } wr_t;
   wr_t wq[$];

   typedef struct {
      logic [15:0] n;
      int unsigned nw;
      int unsigned gmin;
      int unsigned gmax;
      string       name;
   } vec_t;

   logic [31:0] words [0:299];

   always @(negedge clk) begin
      if (lif.imem_we === 1'b1) begin
         wr_t w;
         w.addr = 32'(lif.imem_addr);
         w.data = lif.imem_wdata;
         wq.push_back(w);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      bit ok;
      ok = 1'b0;
      repeat (gap) tick();
      lif.in_valid = 1'b1;
      lif.in_data  = b;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         if (lif.in_ready === 1'b1) ok = 1'b1;
         tick();
      end
      lif.in_valid = 1'b0;
      if (!ok) chkb("byte_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w, input int unsigned gmin, input int unsigned gmax);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] s;
         s = w >> (8 * i);
         send_byte(s[7:0], $urandom_range(gmax, gmin));
      end
   endtask

   task automatic do_reset(input bit check);
      lif.in_valid = 1'b0;
      lif.in_data  = '0;
      lif.restart  = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      if (check) begin
         @(negedge clk);
         chkb("rst_we", lif.imem_we, 1'b0);
         chk("rst_addr", 32'(lif.imem_addr), 32'd0);
         chk("rst_wdata", lif.imem_wdata, 32'd0);
         chkb("rst_core_rst", lif.core_rst, 1'b1);
         chkb("rst_done", lif.done, 1'b0);
         chkb("rst_err", lif.err, 1'b0);
         chk("rst_word_cnt", 32'(lif.word_cnt), 32'd0);
         chkb("rst_in_ready", lif.in_ready, 1'b1);
         tick();
      end
      rst = 1'b1;
      wq.delete();
   endtask

   task automatic load(input logic [15:0] n, input int unsigned nw,
                       input int unsigned gmin, input int unsigned gmax);
      send_byte(n[7:0], $urandom_range(gmax, gmin));
      send_byte(n[15:8], $urandom_range(gmax, gmin));
      for (int k = 0; k < int'(nw); k++) send_word(words[k], gmin, gmax);
   endtask

   // A legal header of N words produces writes k -> words[k] for k < N, in order.
   task automatic verify(input string tag, input logic [15:0] n);
      int unsigned expw;
      int unsigned lim;
      bit legal;
      repeat (3) tick();
      @(negedge clk);
      legal = (32'(n) <= DEPTH);
      expw  = legal ? 32'(n) : 0;
      chk({tag, "_nwrites"}, 32'(wq.size()), expw);
      lim = (wq.size() < expw) ? wq.size() : expw;
      for (int k = 0; k < int'(lim); k++) begin
         chk($sformatf("%s_addr%0d", tag, k), wq[k].addr, 32'(k));
         chk($sformatf("%s_data%0d", tag, k), wq[k].data, words[k]);
      end
      chkb({tag, "_done"}, lif.done, legal);
      chkb({tag, "_err"}, lif.err, !legal);
      chkb({tag, "_core_rst"}, lif.core_rst, !legal);
      chk({tag, "_word_cnt"}, 32'(lif.word_cnt), expw);
      chkb({tag, "_in_ready"}, lif.in_ready, 1'b0);
      tick();
   endtask

   initial begin
      #900_000;
      $fatal(1, "FAIL watchdog: simulation did not finish");
   end

   initial begin
      vec_t vt[7];
      logic [15:0] rn;

      lif.in_valid = 1'b0;
      lif.in_data  = '0;
      lif.restart  = 1'b0;

      vt[0] = '{16'd3,     3,  0, 0, "b2b3"};
      vt[1] = '{16'd3,     3,  1, 3, "bp3"};
      vt[2] = '{16'd1,     1,  0, 2, "one"};
      vt[3] = '{16'd40,    40, 0, 1, "forty"};
      vt[4] = '{16'd300,   0,  0, 0, "over300"};
      vt[5] = '{16'hFFFF,  0,  0, 0, "overmax"};
      vt[6] = '{16'd0,     0,  0, 2, "empty"};

      do_reset(1'b1);

      for (int v = 0; v < 7; v++) begin
         do_reset(1'b0);
         for (int k = 0; k < 300; k++) words[k] = $urandom;
         load(vt[v].n, vt[v].nw, vt[v].gmin, vt[v].gmax);
         verify(vt[v].name, vt[v].n);
      end

      // Basic load with exact output latency.
      do_reset(1'b0);
      words[0] = 32'h00500093;
      words[1] = 32'h00100213;
      words[2] = 32'h00500393;
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      send_word(words[0], 0, 0);
      send_word(words[1], 0, 0);
      send_word(words[2], 0, 0);
      @(negedge clk);
      chkb("basic_t1_we", lif.imem_we, 1'b1);
      chk("basic_t1_addr", 32'(lif.imem_addr), 32'd2);
      chk("basic_t1_data", lif.imem_wdata, 32'h00500393);
      chkb("basic_t1_core_rst", lif.core_rst, 1'b1);
      chk("basic_t1_word_cnt", 32'(lif.word_cnt), 32'd3);
      tick();
      @(negedge clk);
      chkb("basic_t2_we", lif.imem_we, 1'b0);
      chkb("basic_t2_core_rst", lif.core_rst, 1'b0);
      chkb("basic_t2_done", lif.done, 1'b1);
      tick();
      verify("basic", 16'd3);

      // Same stream with 1-3 idle cycles before every byte.
      do_reset(1'b0);
      load(16'd3, 3, 1, 3);
      verify("basic_bp", 16'd3);

      // Empty program runs the cycle after the header.
      do_reset(1'b0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      chkb("empty_core_rst", lif.core_rst, 1'b0);
      chkb("empty_done", lif.done, 1'b1);
      tick();
      verify("empty_hand", 16'd0);

      // Oversize header, then restart re-arms.
      do_reset(1'b0);
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      chkb("over_err", lif.err, 1'b1);
      chkb("over_in_ready", lif.in_ready, 1'b0);
      chkb("over_core_rst", lif.core_rst, 1'b1);
      tick();
      lif.restart = 1'b1;
      @(negedge clk);
      chkb("over_rs_in_ready", lif.in_ready, 1'b0);
      tick();
      lif.restart = 1'b0;
      @(negedge clk);
      chkb("over_post_err", lif.err, 1'b0);
      chkb("over_post_in_ready", lif.in_ready, 1'b1);
      chkb("over_post_core_rst", lif.core_rst, 1'b1);
      chk("over_nwrites", 32'(wq.size()), 32'd0);
      tick();

      // Full capacity: word k = k.
      do_reset(1'b0);
      for (int k = 0; k < 256; k++) words[k] = 32'(k);
      load(16'd256, 256, 0, 0);
      verify("cap", 16'd256);
      if (wq.size() == 256) chk("cap_last_data", wq[255].data, 32'h000000FF);

      // Abort by restart on byte 2 of word 1, then reload.
      for (int pass = 0; pass < 2; pass++) begin
         logic [31:0] w1;
         do_reset(1'b0);
         words[0] = $urandom;
         w1 = $urandom;
         send_byte(8'h02, 0);
         send_byte(8'h00, 0);
         send_word(words[0], 0, 0);
         send_byte(w1[7:0], 0);
         send_byte(w1[15:8], 0);
         if (pass == 0) begin
            lif.restart  = 1'b1;
            lif.in_valid = 1'b1;
            lif.in_data  = w1[23:16];
            @(negedge clk);
            chkb("abort_rs_in_ready", lif.in_ready, 1'b0);
            tick();
            lif.restart  = 1'b0;
            lif.in_valid = 1'b0;
            repeat (3) tick();
            @(negedge clk);
            chk("abort_rs_nwrites", 32'(wq.size()), 32'd1);
            chk("abort_rs_word_cnt", 32'(lif.word_cnt), 32'd0);
            chkb("abort_rs_core_rst", lif.core_rst, 1'b1);
            chkb("abort_rs_done", lif.done, 1'b0);
            tick();
         end else begin
            do_reset(1'b1);
            repeat (3) tick();
            chk("abort_rst_nwrites", 32'(wq.size()), 32'd0);
         end
         wq.delete();
         words[0] = 32'hDEADBEEF;
         load(16'd1, 1, 0, 0);
         verify(pass == 0 ? "reload_rs" : "reload_rst", 16'd1);
      end

      // Random loads against the model.
      for (int it = 0; it < 6; it++) begin
         do_reset(1'b0);
         rn = 16'($urandom_range(24, 1));
         for (int k = 0; k < 24; k++) words[k] = $urandom;
         load(rn, 32'(rn), 0, 2);
         verify($sformatf("rand%0d", it), rn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader for the sequential RISC-V core's instruction memory; the write-side counterpart to the core's instruction fetch.
- Holds the core in reset while it receives a length header and little-endian 32-bit instruction words over a valid/ready byte interface.
- Writes each word to instruction memory, then releases the core to run.
- Reports done/error status.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity DEPTH = 2^ADDR_W words (256)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle
restart  input  1  single-cycle pulse; abort/re-arm loader
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word index being written
imem_wdata  output  32  instruction word
core_rst  output  1  active-high reset to core; 1 until program loaded
done  output  1  program loaded, core running
err  output  1  length header exceeded DEPTH (sticky until restart/rst)
word_cnt  output  16  words written so far in current load

Behaviour:
- Reset (rst==0 at posedge):
  - state=LEN0; all counters and the assembly register cleared.
  - Outputs: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0, word_cnt=0.
  - rst mid-load discards the partial word; nothing further is written.
- Handshake:
  - A byte transfers on the posedge where in_valid && in_ready.
  - in_ready = (state in {LEN0, LEN1, LOAD}) && !restart. It is combinational from state and restart only, never from in_valid.
  - in_valid gaps are allowed at any byte position with no effect on data.
- States:
  - LEN0: capture byte as N[7:0] -> LEN1.
  - LEN1: capture byte as N[15:8]; then, using the full 16-bit N:
    - N==0 -> RUN (no writes).
    - N>DEPTH -> ERROR.
    - otherwise -> LOAD.
  - LOAD: byte_idx (2-bit) counts 0..3. Bytes fill the assembly register little-endian: byte0 -> [7:0] ... byte3 -> [31:24].
  - LOAD, on acceptance of byte_idx==3:
    - Next cycle: imem_we=1, imem_wdata=assembled word, imem_addr=word_cnt[ADDR_W-1:0].
    - word_cnt increments on that same edge.
    - If this was word N-1 -> DRAIN, else remain in LOAD with byte_idx=0.
  - DRAIN: one cycle during which the final write strobe is asserted. in_ready=0 -> RUN.
  - RUN: core_rst=0, done=1, in_ready=0. Extra stream bytes are not accepted.
  - ERROR: err=1, core_rst=1, in_ready=0, no writes.
- Latency:
  - Last byte accepted in cycle T -> imem_we high in cycle T+1 -> core_rst=0 and done=1 from cycle T+2.
  - This guarantees the final word lands before the first fetch.
- imem_we is a single-cycle pulse per word. imem_addr and imem_wdata hold their last values when imem_we=0.
- restart (any state):
  - Next state is LEN0 with core_rst=1, done=0, err=0, word_cnt=0, byte_idx=0.
  - A concurrent byte is not accepted (in_ready=0).
  - A write strobe already scheduled for the restart cycle still completes; no later writes occur.
- Width rules:
  - N is 16-bit unsigned and word_cnt is 16-bit.
  - N==DEPTH is legal and fills addresses 0..DEPTH-1 with no wrap.
  - imem_addr never wraps within a legal load.

Test Plan:
- Basic load: send 03 00, then the words 00500093, 00100213, 00500393 as little-endian bytes, back-to-back. Required:
  - Three imem_we pulses at addr 0, 1, 2 with exactly those words.
  - core_rst falls 2 cycles after the last byte; done=1; word_cnt=3.
- Empty program: send 00 00 -> no imem_we; core_rst=0 and done=1 the cycle after the second header byte; word_cnt=0.
- Oversize: send 01 01 (N=257) with DEPTH=256. Required:
  - err=1, in_ready=0, core_rst stays 1, no writes.
  - A restart pulse clears err and in_ready returns to 1 in LEN0.
- Backpressure: basic-load stream with in_valid deasserted for 1-3 random cycles between every byte -> identical writes and data to the basic-load case; no extra or duplicate strobes.
- Capacity boundary: N=256 with word k = k -> 256 writes; last at addr 255 with data 0x000000FF; done=1; no write to addr 0 after the first.
- Abort cases:
  - restart asserted alongside byte 2 of word 1 -> that byte is not accepted; no write for word 1.
  - Reload with N=1, word DEADBEEF -> write at addr 0, done=1.
  - Repeat with rst=0 in place of restart -> same result; outputs hold reset values during rst.
